mux8_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 8-input, WIDTH-bit multiplexer among eight requesters. Each cycle the output register is free, it selects the next requesting input in rotating priority, drives the mux select, captures the selected data into a registered output and acknowledges the winner with a one-cycle grant. The downstream consumer drains the output through a valid/ready handshake. It sits in front of the 8:1 combinational mux datapath and replaces the free-running select of a bench with a fair, flow-controlled scheduler.

---
 rtl/mux8_rr_arbiter.sv | 94 +++++++++
 tb/tb_mux8_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler for a shared 8:1 WIDTH-bit mux with a registered,
// valid/ready-drained output stage and a wrapping load counter.
module mux8_rr_arbiter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [WIDTH-1:0] i5,
   input  logic [WIDTH-1:0] i6,
   input  logic [WIDTH-1:0] i7,
   output logic [7:0]       gnt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_sel,
   input  logic             out_ready,
   output logic [7:0]       xfer_cnt
);

   // Output handshake: a transfer completes on any rising edge where
   // out_valid && out_ready; out_valid never drops while out_ready is low, and
   // out_data/out_sel stay stable until that edge.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   logic [2:0]       ptr;
   logic             load_en;
   logic             load;
   logic             found;
   logic [2:0]       idx;
   logic [2:0]       win;
   logic [WIDTH-1:0] mux_out;

   assign out_valid = (state == FULL);
   assign load_en   = !out_valid || out_ready;
   assign load      = load_en && (|req);

   // Rotating-priority search starting at ptr; 3-bit index arithmetic wraps 7->0.
   always_comb begin
      found = 1'b0;
      idx   = 3'd0;
      win   = 3'd0;
      for (int j = 0; j < 8; j++) begin
         idx = ptr + 3'(j);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      gnt = 8'h00;
      if (load && !rst) gnt[win] = 1'b1;
   end

   always_comb begin
      case (win)
         3'd0:    mux_out = i0;
         3'd1:    mux_out = i1;
         3'd2:    mux_out = i2;
         3'd3:    mux_out = i3;
         3'd4:    mux_out = i4;
         3'd5:    mux_out = i5;
         3'd6:    mux_out = i6;
         default: mux_out = i7;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         ptr      <= 3'd0;
         out_data <= '0;
         out_sel  <= 3'd0;
         xfer_cnt <= 8'd0;
      end else if (load) begin
         // Covers both the EMPTY fill and the back-to-back drain+refill.
         state    <= FULL;
         out_data <= mux_out;
         out_sel  <= win;
         ptr      <= win + 3'd1;
         xfer_cnt <= xfer_cnt + 8'd1;
      end else if (state == FULL && out_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomised and directed checks of mux8_rr_arbiter against a rule-level
// reference model (rotating search, occupancy flag, wrapping counter).
module tb_mux8_rr_arbiter;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [7:0]   req = 8'h00;
   logic [W-1:0] din[8];
   logic [7:0]   gnt;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [2:0]   out_sel;
   logic         out_ready = 1'b0;
   logic [7:0]   xfer_cnt;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit           m_valid;
   int           m_ptr;
   logic [W-1:0] m_data;
   int           m_sel;
   int           m_cnt;
   logic [W-1:0] exp_q[$];

   mux8_rr_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req),
      .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
      .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
      .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic model_reset();
      m_valid = 0;
      m_ptr   = 0;
      m_data  = '0;
      m_sel   = 0;
      m_cnt   = 0;
      exp_q.delete();
   endtask

   function automatic int model_winner(input logic [7:0] r);
      for (int j = 0; j < 8; j++)
         if (r[(m_ptr + j) % 8]) return (m_ptr + j) % 8;
      return -1;
   endfunction

   // Called just after a rising edge; asserts rst asynchronously and leaves
   // the bench just after a rising edge with rst released.
   task automatic apply_reset();
      #2 rst = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // driver: one clock cycle with the given inputs; reports gnt seen before the
   // edge, the model's expected gnt, and whether a drain happened (with data).
   task automatic cycle(input logic [7:0] r, input logic rdy,
                        output logic [7:0] g_obs, output logic [7:0] g_exp,
                        output bit drained, output logic [W-1:0] d_obs);
      int  w;
      bit  le;
      req = r;
      out_ready = rdy;
      #1;
      g_obs   = gnt;
      d_obs   = out_data;
      drained = m_valid && rdy;
      le      = !m_valid || rdy;
      w       = model_winner(r);
      g_exp   = (le && w >= 0) ? (8'h01 << w) : 8'h00;
      @(posedge clk);
      if (le && w >= 0) begin
         m_data  = din[w];
         m_sel   = w;
         m_valid = 1;
         m_ptr   = (w + 1) % 8;
         m_cnt   = (m_cnt + 1) % 256;
         exp_q.push_back(din[w]);
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic set_din_index();
      for (int k = 0; k < 8; k++) din[k] = W'(k);
   endtask

   task automatic test_reset();
      logic [7:0] g;
      apply_reset();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
      tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_data got %0d want 0", out_data); end
      tests++; if (out_sel !== 3'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", out_sel); end
      tests++; if (xfer_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt); end
      // gnt must be silent while rst is held, even with requests and ready
      rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
      #1 g = gnt;
      tests++; if (g !== 8'h00) begin fails++; $display("FAIL reset_gnt got %h want 00", g); end
      apply_reset();
   endtask

   task automatic test_walk();
      logic [7:0] go, ge; bit dr; logic [W-1:0] dd;
      apply_reset();
      set_din_index();
      for (int k = 0; k < 8; k++) begin
         cycle(8'hFF, 1'b1, go, ge, dr, dd);
         tests++; if (go !== ge || go !== (8'h01 << k)) begin fails++; $display("FAIL walk_gnt[%0d] got %h want %h", k, go, ge); end
         tests++; if (out_sel !== 3'(k) || out_data !== W'(k) || out_valid !== 1'b1) begin
            fails++; $display("FAIL walk_out[%0d] got sel=%0d data=%0d v=%b want %0d", k, out_sel, out_data, out_valid, k);
         end
      end
      tests++; if (xfer_cnt !== 8'd8) begin fails++; $display("FAIL walk_cnt got %0d want 8", xfer_cnt); end
   endtask

   task automatic test_alternate();
      logic [7:0] go, ge; bit dr; logic [W-1:0] dd;
      apply_reset();
      set_din_index();
      for (int n = 0; n < 4; n++) begin
         cycle(8'b1000_0100, 1'b1, go, ge, dr, dd);
         tests++; if (go !== ge || go !== ((n % 2) ? 8'h80 : 8'h04)) begin fails++; $display("FAIL alt_gnt[%0d] got %h want %h", n, go, ge); end
         tests++; if (out_data !== m_data || out_data !== ((n % 2) ? W'(7) : W'(2))) begin
            fails++; $display("FAIL alt_data[%0d] got %0d want %0d", n, out_data, m_data);
         end
      end
   endtask

   task automatic test_stall_and_drain();
      logic [7:0] go, ge; bit dr; logic [W-1:0] dd;
      apply_reset();
      set_din_index();
      cycle(8'b0000_1000, 1'b1, go, ge, dr, dd);
      tests++; if (go !== 8'h08) begin fails++; $display("FAIL stall_load got %h want 08", go); end
      for (int n = 0; n < 5; n++) begin
         cycle(8'hFF, 1'b0, go, ge, dr, dd);
         tests++; if (go !== 8'h00 || out_valid !== 1'b1 || out_data !== W'(3)) begin
            fails++; $display("FAIL stall_hold[%0d] got gnt=%h v=%b data=%0d want 00/1/3", n, go, out_valid, out_data);
         end
      end
      cycle(8'hFF, 1'b1, go, ge, dr, dd);
      tests++; if (go !== 8'h10 || go !== ge) begin fails++; $display("FAIL stall_release got %h want 10", go); end
      // drain with no requests: out_valid falls, data retained, pointer kept at 5
      cycle(8'h00, 1'b1, go, ge, dr, dd);
      tests++; if (out_valid !== 1'b0 || out_data !== W'(4) || out_sel !== 3'd4) begin
         fails++; $display("FAIL drain_empty got v=%b data=%0d sel=%0d want 0/4/4", out_valid, out_data, out_sel);
      end
      for (int n = 0; n < 3; n++) cycle(8'h00, $urandom_range(0, 1), go, ge, dr, dd);
      tests++; if (out_valid !== 1'b0 || xfer_cnt !== 8'd2) begin fails++; $display("FAIL empty_hold got v=%b cnt=%0d want 0/2", out_valid, xfer_cnt); end
      cycle(8'hFF, 1'b0, go, ge, dr, dd);
      tests++; if (go !== 8'h20) begin fails++; $display("FAIL ptr_kept got %h want 20", go); end
   endtask

   task automatic test_wrap();
      logic [7:0] go, ge; bit dr; logic [W-1:0] dd;
      int bad = 0;
      apply_reset();
      set_din_index();
      for (int n = 0; n < 256; n++) begin
         cycle(8'hFF, 1'b1, go, ge, dr, dd);
         if (go !== ge) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL wrap_gnts got %0d bad want 0", bad); end
      tests++; if (xfer_cnt !== 8'd0) begin fails++; $display("FAIL wrap_cnt got %0d want 0", xfer_cnt); end
      tests++; if (out_sel !== 3'd7) begin fails++; $display("FAIL wrap_lastsel got %0d want 7", out_sel); end
      cycle(8'hFF, 1'b1, go, ge, dr, dd);
      tests++; if (go !== 8'h01) begin fails++; $display("FAIL ptr7_wrap got %h want 01", go); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] go, ge; bit dr; logic [W-1:0] dd;
      apply_reset();
      set_din_index();
      cycle(8'b0100_0000, 1'b1, go, ge, dr, dd);
      req = 8'hFF; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 3'd0 || xfer_cnt !== 8'd0 || gnt !== 8'h00) begin
         fails++; $display("FAIL mid_reset got v=%b data=%0d sel=%0d cnt=%0d gnt=%h want zeros", out_valid, out_data, out_sel, xfer_cnt, gnt);
      end
      req = 8'h00;
      model_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      cycle(8'b0110_0000, 1'b1, go, ge, dr, dd);
      tests++; if (go !== 8'h20 || go !== ge) begin fails++; $display("FAIL mid_first got %h want 20", go); end
   endtask

   task automatic test_random();
      logic [7:0] go, ge, r; bit dr; logic [W-1:0] dd, e;
      int bad_g = 0, bad_o = 0, bad_s = 0;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 8; k++) din[k] = W'($urandom_range(0, 7));
         r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         cycle(r, ($urandom_range(0, 3) != 0), go, ge, dr, dd);
         if (go !== ge) bad_g++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 3'(m_sel))) || xfer_cnt !== 8'(m_cnt)) bad_o++;
         if (dr) begin
            e = exp_q.pop_front();
            if (dd !== e) bad_s++;
         end
      end
      tests++; if (bad_g != 0) begin fails++; $display("FAIL rand_gnt got %0d bad cycles want 0", bad_g); end
      tests++; if (bad_o != 0) begin fails++; $display("FAIL rand_out got %0d bad cycles want 0", bad_o); end
      tests++; if (bad_s != 0) begin fails++; $display("FAIL rand_scoreboard got %0d bad drains want 0", bad_s); end
      tests++; if (exp_q.size() != (m_valid ? 1 : 0)) begin fails++; $display("FAIL rand_queue got %0d left want %0d", exp_q.size(), m_valid ? 1 : 0); end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) din[k] = '0;
      model_reset();
      @(posedge clk) #1;
      test_reset();
      test_walk();
      test_alternate();
      test_stall_and_drain();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
